led_matrix_scanner: RTL and testbench

//  Self-timed column scanner for an NxN LED matrix showing the Conway cell grid.

---
 rtl/led_matrix_scanner.sv | 105 ++++++++++
 tb/tb_led_matrix_scanner.sv | 138 +++++++++++++
 2 files changed

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: self-timed NxN column scanner with blanking gap and tear-free shadow frame.
// Optional LED_DIM_EN adds a latched 4-bit brightness that limits row drive within each dwell.
module led_matrix_scanner #(
  parameter int N           = 8,
  parameter int DWELL_TICKS = 1000,
  parameter int BLANK_TICKS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [N*N-1:0]       cells,
`ifdef LED_DIM_EN
  input  logic [3:0]           brightness,
`endif
  output logic [N-1:0]         rows,
  output logic [N-1:0]         cols,
  output logic [$clog2(N)-1:0] col_idx,
  output logic                 frame_done
);
  localparam int CW   = $clog2(N);
  localparam int MAXT = DWELL_TICKS > BLANK_TICKS ? DWELL_TICKS : BLANK_TICKS;
  localparam int TW   = $clog2(MAXT + 1);
  localparam logic [TW-1:0] DWELL_LD = TW'(DWELL_TICKS - 1);
  localparam logic [TW-1:0] GAP_LD   = BLANK_TICKS == 0 ? DWELL_LD : TW'(BLANK_TICKS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(N - 1);
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
  localparam state_t GAP_ST = BLANK_TICKS == 0 ? DRIVE : BLANK;
  if (N < 2 || N > 16) begin : g_bad_n
    $error("led_matrix_scanner: N must be in 2..16");
  end
  if (DWELL_TICKS < 1) begin : g_bad_dwell
    $error("led_matrix_scanner: DWELL_TICKS must be >= 1");
  end
  state_t         state_q, state_d;
  logic [CW-1:0]  col_q, col_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [N*N-1:0] shadow_q, shadow_d;
  logic [N-1:0]   rows_q, rows_d, cols_q, cols_d, col_cells;
  logic           frame_done_q, frame_done_d, dwell_end, latch, lit;
  logic [N-1:0]   row_bits [N];
  always_comb begin
    dwell_end    = state_q == DRIVE && timer_q == '0;
    latch        = ena && (state_q == IDLE || (dwell_end && col_q == LAST_COL));
    shadow_d     = latch ? cells : shadow_q;
    frame_done_d = latch && state_q == DRIVE;
    state_d      = state_q;
    col_d        = col_q;
    timer_d      = timer_q == '0 ? '0 : timer_q - 1'b1;
    if (!ena) begin
      state_d = IDLE;
      col_d   = '0;
      timer_d = '0;
    end else if (state_q == IDLE || dwell_end) begin
      state_d = GAP_ST;
      timer_d = GAP_LD;
      col_d   = (state_q == IDLE || col_q == LAST_COL) ? '0 : col_q + 1'b1;
    end else if (state_q == BLANK && timer_q == '0) begin
      state_d = DRIVE;
      timer_d = DWELL_LD;
    end
  end
  genvar r;
  for (r = 0; r < N; r++) begin : g_row
    assign row_bits[r]  = shadow_d[N*r +: N];
    assign col_cells[r] = row_bits[r][col_d];
  end
`ifdef LED_DIM_EN
  logic [3:0] bright_q, bright_d;
  // lit while (elapsed dwell cycles)*16 < (brightness+1)*DWELL_TICKS
  always_comb begin
    bright_d = latch ? brightness : bright_q;
    lit      = (DWELL_TICKS - 1 - int'(timer_d)) * 16 < (int'(bright_d) + 1) * DWELL_TICKS;
  end
  always_ff @(posedge clk) bright_q <= !rst ? 4'hF : bright_d;
`else
  assign lit = 1'b1;
`endif
  always_comb begin
    cols_d = state_d == DRIVE ? {{(N-1){1'b0}}, 1'b1} << col_d : '0;
    rows_d = (state_d == DRIVE && lit) ? ~col_cells : '1;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      timer_q      <= '0;
      shadow_q     <= '0;
      rows_q       <= '1;
      cols_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      timer_q      <= timer_d;
      shadow_q     <= shadow_d;
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign rows       = rows_q;
  assign cols       = cols_q;
  assign col_idx    = col_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: scoreboard bench for led_matrix_scanner (N=4, DWELL=4, BLANK=2).
module tb_led_matrix_scanner;
  logic        clk = 1'b0;
  logic        rst, ena;
  logic [15:0] cells;
  logic [3:0]  rows, cols;
  logic [1:0]  col_idx;
  logic        frame_done;
  logic [10:0] expq [$];
  int          tests = 0;
  int          failed = 0;
  always #5 clk = ~clk;
  led_matrix_scanner #(.N(4), .DWELL_TICKS(4), .BLANK_TICKS(2)) dut (
    .clk(clk), .rst(rst), .ena(ena), .cells(cells),
`ifdef LED_DIM_EN
    .brightness(4'hF),
`endif
    .rows(rows), .cols(cols), .col_idx(col_idx), .frame_done(frame_done)
  );
  // monitor: one expected output record per clock edge
  always @(posedge clk) begin
    logic [10:0] e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      tests++;
      if ({rows, cols, col_idx, frame_done} !== e) begin
        failed++;
        $display("FAIL out @%0t: got rows=%h cols=%h idx=%0d fd=%b, want rows=%h cols=%h idx=%0d fd=%b",
                 $time, rows, cols, col_idx, frame_done, e[10:7], e[6:3], e[2:1], e[0]);
      end
      tests++;
      if ($countones(cols) > 1) begin
        failed++;
        $display("FAIL onehot @%0t: got cols=%b, want at most one bit set", $time, cols);
      end
    end
  end
  function automatic logic [3:0] diag(input int x);
    logic [3:0] one = 4'b0001;
    return 4'hF ^ (one << x);
  endfunction
  function automatic logic [3:0] anti(input int x);
    logic [3:0] top = 4'b1000;
    return 4'hF ^ (top >> x);
  endfunction
  task automatic step(input logic [3:0] er, input logic [3:0] ec, input int ei, input logic ef);
    expq.push_back({er, ec, 2'(ei), ef});
    @(negedge clk);
  endtask
  task automatic run_col(input int x, input logic [3:0] er, input logic ef);
    logic [3:0] one = 4'b0001;
    step(4'hF, 4'h0, x, ef);
    step(4'hF, 4'h0, x, 1'b0);
    repeat (4) step(er, one << x, x, 1'b0);
  endtask
`ifdef LED_DIM_EN
  logic       rst2, ena2;
  logic [3:0] br2, rows2, cols2;
  logic [1:0] idx2;
  logic       fd2;
  led_matrix_scanner #(.N(4), .DWELL_TICKS(16), .BLANK_TICKS(2)) u_dim (
    .clk(clk), .rst(rst2), .ena(ena2), .cells(16'hFFFF), .brightness(br2),
    .rows(rows2), .cols(cols2), .col_idx(idx2), .frame_done(fd2)
  );
  task automatic dim_run(input logic [3:0] b, input int want);
    int lit = 0;
    rst2 = 1'b0; ena2 = 1'b0;
    @(negedge clk);
    rst2 = 1'b1; ena2 = 1'b1; br2 = b;
    @(negedge clk);
    br2 = 4'hF;
    for (int i = 0; i < 20; i++) begin
      if (rows2 == 4'h0) lit++;
      @(negedge clk);
    end
    ena2 = 1'b0;
    tests++;
    if (lit != want) begin
      failed++;
      $display("FAIL dim b=%0d: got %0d lit cycles, want %0d", b, lit, want);
    end
  endtask
  initial begin
    rst2 = 1'b0; ena2 = 1'b0; br2 = 4'hF;
  end
`endif
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b0; ena = 1'b1; cells = 16'hFFFF;
    repeat (3) step(4'hF, 4'h0, 0, 1'b0);
    rst = 1'b1; cells = 16'h8421;
    for (int x = 0; x < 4; x++) run_col(x, diag(x), 1'b0);
    for (int x = 0; x < 4; x++) run_col(x, diag(x), x == 0);
    run_col(0, diag(0), 1'b1);
    run_col(1, diag(1), 1'b0);
    cells = 16'h0000;
    run_col(2, diag(2), 1'b0);
    run_col(3, diag(3), 1'b0);
    run_col(0, 4'hF, 1'b1);
    cells = 16'h8421;
    for (int x = 1; x < 4; x++) run_col(x, 4'hF, 1'b0);
    run_col(0, diag(0), 1'b1);
    run_col(1, diag(1), 1'b0);
    step(4'hF, 4'h0, 2, 1'b0);
    step(4'hF, 4'h0, 2, 1'b0);
    step(diag(2), 4'h4, 2, 1'b0);
    ena = 1'b0;
    repeat (3) step(4'hF, 4'h0, 0, 1'b0);
    ena = 1'b1; cells = 16'h1248;
    for (int x = 0; x < 4; x++) run_col(x, anti(x), 1'b0);
    run_col(0, anti(0), 1'b1);
    for (int x = 1; x < 3; x++) run_col(x, anti(x), 1'b0);
    step(4'hF, 4'h0, 3, 1'b0);
    rst = 1'b0;
    step(4'hF, 4'h0, 0, 1'b0);
    rst = 1'b1;
    for (int x = 0; x < 4; x++) run_col(x, anti(x), 1'b0);
    @(posedge clk);
    #2;
    tests++;
    if (expq.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d unchecked records, want 0", expq.size());
    end
`ifdef LED_DIM_EN
    dim_run(4'd7, 8);
    dim_run(4'd15, 16);
    dim_run(4'd0, 1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
